ram_dp_sync_be: RTL and testbench
=================================

Name: ram_dp_sync_be

Overview:
- Parametrised synchronous true dual-port RAM; the clocked successor to the team's asynchronous dual-port RAM.
- Two independent read/write ports share one clock.
- Data paths are split in/out; there are no tri-states.
- Adds per-byte write enables, a configurable read pipeline (1 or 2 cycles) with a valid strobe, a selectable read-during-write mode, and deterministic same-address write arbitration with a collision flag.
- Serves as the storage element for the synchronous FIFO and similar buffers.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane
NUM_BYTES, DATA_WIDTH/BYTE_WIDTH, number of byte lanes (derived, do not override)
ADDR_WIDTH, 8, address width
RAM_DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 2^ADDR_WIDTH
READ_LATENCY, 1, cycles from read request edge to rdata valid; legal values 1 or 2
WRITE_MODE, 0, cross-port same-address read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
en_0  in  1  port 0 access request
we_0  in  1  port 0 write (1) / read (0), qualified by en_0
be_0  in  NUM_BYTES  port 0 byte write enables
addr_0  in  ADDR_WIDTH  port 0 address
wdata_0  in  DATA_WIDTH  port 0 write data
rdata_0  out  DATA_WIDTH  port 0 read data
rvalid_0  out  1  port 0 read data valid, one-cycle pulse per read
en_1, we_1, be_1, addr_1, wdata_1, rdata_1, rvalid_1: same as port 0, for port 1
coll  out  1  registered pulse: both ports wrote the same address with overlapping byte enables

Behaviour:
- Reset (async assert, sync release): rdata_x=0, rvalid_x=0, coll=0, all read-pipeline stages cleared (in-flight reads squashed, no rvalid). Memory contents are not reset.
- Write: en_x&&we_x at edge T writes lanes with be_x[i]=1 into mem[addr_x]; other lanes are unchanged. be_x=0 is a legal no-op write. Writes never raise rvalid_x.
- Read: en_x&&!we_x at edge T samples mem[addr_x].
  - READ_LATENCY=1: rdata_x/rvalid_x valid after edge T, i.e. during cycle T+1.
  - READ_LATENCY=2: an extra output register; valid during cycle T+2.
  - Back-to-back reads are fully pipelined, one per cycle.
- rdata_x holds its last value when rvalid_x=0; it is not zeroed.
- Cross-port read-during-write (port x reads address A while port y writes A at the same edge):
  - WRITE_MODE=0: returns the pre-write word.
  - WRITE_MODE=1: returns the word after the write. Lanes with be_y=1 come from wdata_y; other lanes come from memory.
- Same-port read-then-write on consecutive cycles needs no special handling.
- Dual write to the same address:
  - Per lane, port 0 wins where both be bits are set.
  - Lanes enabled only on port 1 take wdata_1.
  - If (be_0&be_1)!=0, coll=1 for exactly the cycle after the edge; otherwise coll=0.
- Address >= RAM_DEPTH: writes are ignored; reads return 0 with normal rvalid timing.
- en_x=0: no access; we_x, be_x, addr_x and wdata_x are don't-care.
- Reset during an in-flight read: data is discarded and rvalid_x stays 0 until a new read is issued after reset release.
- The memory array has no async reset so it infers block RAM. Output and valid registers carry the async reset.

Test Plan:
- Byte writes, DATA_WIDTH=32:
  - Write 0x11223344 to addr 5 with be=4'hF via port 0.
  - Then write 0xAABBCCDD to addr 5 with be=4'b0101 via port 1.
  - Read addr 5 on port 0 -> rdata_0=0x11BB33DD, rvalid_0 pulses 1 cycle after the request (READ_LATENCY=1), 2 cycles after (READ_LATENCY=2).
- Pipelined reads:
  - Preload addr0..3 = 0x10..0x13.
  - Read addr0..3 on consecutive cycles on port 1 -> rvalid_1 is high 4 consecutive cycles, rdata_1 sequence 0x10,0x11,0x12,0x13.
- Read-during-write:
  - mem[7]=0x55; port 0 writes 0xA5 to addr 7 while port 1 reads addr 7 at the same edge.
  - WRITE_MODE=0 -> rdata_1=0x55; WRITE_MODE=1 -> rdata_1=0xA5.
  - Subsequent read returns 0xA5.
- Write collision, DATA_WIDTH=16:
  - Both ports write addr 3, port 0 0x1234 be=2'b11, port 1 0xABCD be=2'b11 -> mem[3]=0x1234, coll=1 for one cycle.
  - Repeat with port 0 be=2'b01, port 1 be=2'b10 -> mem[3]=0xAB34, coll=0.
- Reset mid-read:
  - READ_LATENCY=2; issue a read, assert rst one cycle later -> rvalid_0 never pulses for that read, rdata_0=0, coll=0.
  - Memory contents are preserved: a read after release returns the previous data.
- Range: RAM_DEPTH=200, ADDR_WIDTH=8; write 0xFF to addr 210, then read addr 210 -> rdata=0, and no location 0..199 is changed.

Source files
------------

// File: rtl/ram_dp_sync_be.sv
// Synchronous true dual-port RAM with per-byte write enables.
// Two read/write ports share one clock. Reads take 1 or 2 cycles and
// come with a valid strobe. Cross-port read-during-write is selectable.
// Same-address dual writes resolve per lane with port 0 winning, and a
// collision pulse is raised when the two ports' byte enables overlap.
module ram_dp_sync_be #(
    parameter int DATA_WIDTH   = 8,
    parameter int BYTE_WIDTH   = 8,
    parameter int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_0,
    input  logic                  we_0,
    input  logic [NUM_BYTES-1:0]  be_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic                  rvalid_0,
    input  logic                  en_1,
    input  logic                  we_1,
    input  logic [NUM_BYTES-1:0]  be_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_1,
    output logic                  coll
);

    // Depth as an address-wide-plus-one value so a full 2^ADDR_WIDTH depth still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = RAM_DEPTH[ADDR_WIDTH:0];

    // Replace the lanes of old_word selected by be with the matching lanes of new_word.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  in_range_0_s, in_range_1_s;
    logic                  wr_0_s, wr_1_s, rd_0_s, rd_1_s;
    logic                  same_addr_s;
    logic [DATA_WIDTH-1:0] rd_word_0_s, rd_word_1_s;

    logic [DATA_WIDTH-1:0] s1_data_0_r, s1_data_1_r;
    logic                  s1_valid_0_r, s1_valid_1_r;
    logic                  coll_r;

    assign in_range_0_s = ({1'b0, addr_0} < DEPTH_L);
    assign in_range_1_s = ({1'b0, addr_1} < DEPTH_L);
    assign wr_0_s       = en_0 & we_0 & in_range_0_s;
    assign wr_1_s       = en_1 & we_1 & in_range_1_s;
    assign rd_0_s       = en_0 & ~we_0;
    assign rd_1_s       = en_1 & ~we_1;
    assign same_addr_s  = (addr_0 == addr_1);

    // Lane writes; port 0 is applied last so it wins any lane both ports enable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_1_s && be_1[i]) begin
                mem[addr_1][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_1[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wr_0_s && be_0[i]) begin
                mem[addr_0][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_0[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Port 0 read word: zero out of range, optionally forwarding port 1's concurrent write.
    always_comb begin
        rd_word_0_s = '0;
        if (in_range_0_s) begin
            if ((WRITE_MODE == 1) && wr_1_s && same_addr_s) begin
                rd_word_0_s = lane_merge(mem[addr_0], wdata_1, be_1);
            end else begin
                rd_word_0_s = mem[addr_0];
            end
        end else begin
            rd_word_0_s = '0;
        end
    end

    // Port 1 read word: zero out of range, optionally forwarding port 0's concurrent write.
    always_comb begin
        rd_word_1_s = '0;
        if (in_range_1_s) begin
            if ((WRITE_MODE == 1) && wr_0_s && same_addr_s) begin
                rd_word_1_s = lane_merge(mem[addr_1], wdata_0, be_0);
            end else begin
                rd_word_1_s = mem[addr_1];
            end
        end else begin
            rd_word_1_s = '0;
        end
    end

    // First read stage: captures the word on a read and holds it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data_0_r  <= '0;
            s1_data_1_r  <= '0;
            s1_valid_0_r <= 1'b0;
            s1_valid_1_r <= 1'b0;
        end else begin
            s1_valid_0_r <= rd_0_s;
            s1_valid_1_r <= rd_1_s;
            if (rd_0_s) begin
                s1_data_0_r <= rd_word_0_s;
            end
            if (rd_1_s) begin
                s1_data_1_r <= rd_word_1_s;
            end
        end
    end

    // Collision pulse: both ports write the same in-range word with overlapping lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_r <= 1'b0;
        end else begin
            coll_r <= wr_0_s & wr_1_s & same_addr_s & (|(be_0 & be_1));
        end
    end

    assign coll = coll_r;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data_0_r, s2_data_1_r;
            logic                  s2_valid_0_r, s2_valid_1_r;

            // Second read stage: forwards only valid data so rdata holds between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_data_0_r  <= '0;
                    s2_data_1_r  <= '0;
                    s2_valid_0_r <= 1'b0;
                    s2_valid_1_r <= 1'b0;
                end else begin
                    s2_valid_0_r <= s1_valid_0_r;
                    s2_valid_1_r <= s1_valid_1_r;
                    if (s1_valid_0_r) begin
                        s2_data_0_r <= s1_data_0_r;
                    end
                    if (s1_valid_1_r) begin
                        s2_data_1_r <= s1_data_1_r;
                    end
                end
            end

            assign rdata_0  = s2_data_0_r;
            assign rdata_1  = s2_data_1_r;
            assign rvalid_0 = s2_valid_0_r;
            assign rvalid_1 = s2_valid_1_r;
        end else begin : g_lat1
            assign rdata_0  = s1_data_0_r;
            assign rdata_1  = s1_data_1_r;
            assign rvalid_0 = s1_valid_0_r;
            assign rvalid_1 = s1_valid_1_r;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_sync_be.sv
// Self-checking bench for ram_dp_sync_be: directed scenarios plus random traffic
// compared against a word-array reference model with a queue of pending reads.
module tb_ram_dp_sync_be;

    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int NB    = DW / BW;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int RL    = 2;
    localparam int WM    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_0, we_0, en_1, we_1;
    logic [NB-1:0] be_0, be_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1, rdata_0, rdata_1;
    logic          rvalid_0, rvalid_1, coll;

    ram_dp_sync_be #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
        .READ_LATENCY(RL), .WRITE_MODE(WM)
    ) dut (
        .clk(clk), .rst(rst),
        .en_0(en_0), .we_0(we_0), .be_0(be_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .rdata_0(rdata_0), .rvalid_0(rvalid_0),
        .en_1(en_1), .we_1(we_1), .be_1(be_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .rdata_1(rdata_1), .rvalid_1(rvalid_1),
        .coll(coll)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rd_t           q0[$];
    rd_t           q1[$];
    int            cyc = 0;
    logic          exp_v0 = 1'b0, exp_v1 = 1'b0, exp_coll = 1'b0;
    logic [DW-1:0] exp_d0 = '0, exp_d1 = '0;
    int            vectors = 0;
    int            miscompares = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < NB; i++) if (be[i]) r[i*BW +: BW] = n[i*BW +: BW];
        return r;
    endfunction

    task automatic set_p0(input logic en, input logic we, input logic [NB-1:0] be,
                          input int addr, input logic [DW-1:0] wd);
        en_0 = en; we_0 = we; be_0 = be; addr_0 = AW'(addr); wdata_0 = wd;
    endtask

    task automatic set_p1(input logic en, input logic we, input logic [NB-1:0] be,
                          input int addr, input logic [DW-1:0] wd);
        en_1 = en; we_1 = we; be_1 = be; addr_1 = AW'(addr); wdata_1 = wd;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, '0, 0, '0);
        set_p1(1'b0, 1'b0, '0, 0, '0);
    endtask

    // Apply the current inputs at one edge, update the model, and work out expected outputs.
    task automatic tick();
        logic          w0, w1, c;
        logic [DW-1:0] r;
        w0 = en_0 && we_0 && (int'(addr_0) < DEPTH);
        w1 = en_1 && we_1 && (int'(addr_1) < DEPTH);
        if (en_0 && !we_0) begin
            r = '0;
            if (int'(addr_0) < DEPTH) begin
                r = ref_mem[int'(addr_0)];
                if (WM == 1 && w1 && addr_1 == addr_0) r = merge(r, wdata_1, be_1);
            end
            q0.push_back('{due: cyc + RL, data: r});
        end
        if (en_1 && !we_1) begin
            r = '0;
            if (int'(addr_1) < DEPTH) begin
                r = ref_mem[int'(addr_1)];
                if (WM == 1 && w0 && addr_0 == addr_1) r = merge(r, wdata_0, be_0);
            end
            q1.push_back('{due: cyc + RL, data: r});
        end
        c = w0 && w1 && (addr_0 == addr_1) && ((be_0 & be_1) != '0);
        if (w1) ref_mem[int'(addr_1)] = merge(ref_mem[int'(addr_1)], wdata_1, be_1);
        if (w0) ref_mem[int'(addr_0)] = merge(ref_mem[int'(addr_0)], wdata_0, be_0);
        @(posedge clk);
        #1;
        cyc++;
        exp_coll = c;
        exp_v0 = 1'b0;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            exp_v0 = 1'b1; exp_d0 = q0[0].data; void'(q0.pop_front());
        end
        exp_v1 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            exp_v1 = 1'b1; exp_d1 = q1[0].data; void'(q1.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({rvalid_0, rvalid_1, coll} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 000", {rvalid_0, rvalid_1, coll});
        end
        vectors++;
        if (rdata_0 !== '0 || rdata_1 !== '0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h/%h, expected 0/0", rdata_0, rdata_1);
        end
        rst = 1'b0;
        cyc += 2;
        // Fill every location so later reads have defined contents; writes never raise rvalid.
        for (int i = 0; i < DEPTH / 2; i++) begin
            set_p0(1'b1, 1'b1, '1, 2 * i, DW'($urandom));
            set_p1(1'b1, 1'b1, '1, 2 * i + 1, DW'($urandom));
            tick();
            vectors++;
            if (rvalid_0 !== 1'b0 || rvalid_1 !== 1'b0) begin
                miscompares++;
                $display("FAIL preload_rvalid: got %b%b, expected 00", rvalid_0, rvalid_1);
            end
        end
        idle();
    endtask

    task automatic test_byte_writes();
        set_p0(1'b1, 1'b1, 4'hF, 5, 32'h11223344);
        tick();
        idle();
        set_p1(1'b1, 1'b1, 4'b0101, 5, 32'hAABBCCDD);
        tick();
        idle();
        set_p0(1'b1, 1'b0, 4'h0, 5, 32'h0);
        for (int k = 1; k <= RL + 1; k++) begin
            tick();
            idle();
            vectors++;
            if (rvalid_0 !== (k == RL)) begin
                miscompares++;
                $display("FAIL byte_rvalid k=%0d: got %b, expected %b", k, rvalid_0, (k == RL));
            end
            if (k == RL) begin
                vectors++;
                if (rdata_0 !== 32'h11BB33DD) begin
                    miscompares++;
                    $display("FAIL byte_rdata: got %h, expected 11bb33dd", rdata_0);
                end
            end
        end
    endtask

    task automatic test_pipelined_reads();
        set_p0(1'b1, 1'b1, '1, 0, 32'h10);
        set_p1(1'b1, 1'b1, '1, 1, 32'h11);
        tick();
        set_p0(1'b1, 1'b1, '1, 2, 32'h12);
        set_p1(1'b1, 1'b1, '1, 3, 32'h13);
        tick();
        idle();
        for (int k = 1; k <= RL + 4; k++) begin
            if (k <= 4) set_p1(1'b1, 1'b0, '0, k - 1, '0);
            else idle();
            tick();
            vectors++;
            if (rvalid_1 !== (k >= RL && k <= RL + 3)) begin
                miscompares++;
                $display("FAIL pipe_rvalid k=%0d: got %b", k, rvalid_1);
            end
            if (k >= RL && k <= RL + 3) begin
                vectors++;
                if (rdata_1 !== DW'(32'h10 + k - RL)) begin
                    miscompares++;
                    $display("FAIL pipe_rdata k=%0d: got %h, expected %h", k, rdata_1, 32'h10 + k - RL);
                end
            end
        end
        idle();
    endtask

    task automatic test_rdw();
        logic [DW-1:0] want;
        set_p0(1'b1, 1'b1, '1, 7, 32'h55);
        tick();
        set_p0(1'b1, 1'b1, '1, 7, 32'hA5);
        set_p1(1'b1, 1'b0, '0, 7, '0);
        for (int pass = 0; pass < 2; pass++) begin
            want = (pass == 0 && WM == 0) ? 32'h55 : 32'hA5;
            for (int k = 1; k <= RL; k++) begin
                tick();
                idle();
            end
            vectors++;
            if (rvalid_1 !== 1'b1 || rdata_1 !== want) begin
                miscompares++;
                $display("FAIL rdw pass%0d: got v=%b d=%h, expected v=1 d=%h", pass, rvalid_1, rdata_1, want);
            end
            set_p1(1'b1, 1'b0, '0, 7, '0);
        end
        idle();
        tick();
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                set_p0(1'b1, 1'b1, 4'hF, 3, 32'h00001234);
                set_p1(1'b1, 1'b1, 4'hF, 3, 32'h0000ABCD);
                want = 32'h00001234;
            end else begin
                set_p0(1'b1, 1'b1, 4'b0011, 3, 32'h11111234);
                set_p1(1'b1, 1'b1, 4'b1100, 3, 32'hABCD5678);
                want = 32'hABCD1234;
            end
            tick();
            idle();
            vectors++;
            if (coll !== (pass == 0)) begin
                miscompares++;
                $display("FAIL coll pass%0d: got %b, expected %b", pass, coll, (pass == 0));
            end
            set_p0(1'b1, 1'b0, '0, 3, '0);
            tick();
            idle();
            vectors++;
            if (coll !== 1'b0) begin
                miscompares++;
                $display("FAIL coll_pulse pass%0d: got %b, expected 0", pass, coll);
            end
            repeat (RL - 1) tick();
            vectors++;
            if (rvalid_0 !== 1'b1 || rdata_0 !== want) begin
                miscompares++;
                $display("FAIL coll_data pass%0d: got v=%b d=%h, expected v=1 d=%h", pass, rvalid_0, rdata_0, want);
            end
        end
    endtask

    task automatic test_range();
        set_p0(1'b1, 1'b1, '1, 210, 32'hFFFFFFFF);
        tick();
        set_p0(1'b1, 1'b0, '0, 210, '0);
        tick();
        idle();
        repeat (RL - 1) tick();
        vectors++;
        if (rvalid_0 !== 1'b1 || rdata_0 !== 32'h0) begin
            miscompares++;
            $display("FAIL range_read: got v=%b d=%h, expected v=1 d=0", rvalid_0, rdata_0);
        end
        for (int i = 0; i < DEPTH / 2 + RL; i++) begin
            if (i < DEPTH / 2) begin
                set_p0(1'b1, 1'b0, '0, 2 * i, '0);
                set_p1(1'b1, 1'b0, '0, 2 * i + 1, '0);
            end else begin
                idle();
            end
            tick();
            vectors++;
            if ({rvalid_0, rdata_0, rvalid_1, rdata_1} !== {exp_v0, exp_d0, exp_v1, exp_d1}) begin
                miscompares++;
                $display("FAIL range_sweep i=%0d: got %b/%h %b/%h, expected %b/%h %b/%h", i,
                         rvalid_0, rdata_0, rvalid_1, rdata_1, exp_v0, exp_d0, exp_v1, exp_d1);
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            set_p0($urandom_range(0, 3) != 0, 1'($urandom), NB'($urandom),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 15),
                   DW'($urandom));
            set_p1($urandom_range(0, 3) != 0, 1'($urandom), NB'($urandom),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 15),
                   DW'($urandom));
            tick();
            vectors++;
            if ({rvalid_0, rdata_0, rvalid_1, rdata_1, coll} !==
                {exp_v0, exp_d0, exp_v1, exp_d1, exp_coll}) begin
                miscompares++;
                $display("FAIL random n=%0d: got %b/%h %b/%h c=%b, expected %b/%h %b/%h c=%b", n,
                         rvalid_0, rdata_0, rvalid_1, rdata_1, coll,
                         exp_v0, exp_d0, exp_v1, exp_d1, exp_coll);
            end
        end
        idle();
        repeat (RL) tick();
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] want;
        want = ref_mem[9];
        set_p0(1'b1, 1'b0, '0, 9, '0);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({rvalid_0, coll} !== 2'b00 || rdata_0 !== '0) begin
            miscompares++;
            $display("FAIL midreset_async: got v=%b c=%b d=%h, expected 0/0/0", rvalid_0, coll, rdata_0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += 2;
        q0.delete(); q1.delete();
        exp_d0 = '0; exp_d1 = '0;
        for (int k = 0; k <= RL; k++) begin
            tick();
            vectors++;
            if (rvalid_0 !== 1'b0 || rdata_0 !== '0 || coll !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_squash k=%0d: got v=%b d=%h c=%b, expected 0/0/0", k, rvalid_0, rdata_0, coll);
            end
        end
        set_p0(1'b1, 1'b0, '0, 9, '0);
        tick();
        idle();
        repeat (RL - 1) tick();
        vectors++;
        if (rvalid_0 !== 1'b1 || rdata_0 !== want) begin
            miscompares++;
            $display("FAIL midreset_keep: got v=%b d=%h, expected v=1 d=%h", rvalid_0, rdata_0, want);
        end
    endtask

    initial begin
        test_reset();
        test_byte_writes();
        test_pipelined_reads();
        test_rdw();
        test_collision();
        test_range();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
